// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//   Host-side SPI master for the SPI slave + single-port RAM subsystem.
//   Accepts one command per valid/ready handshake, serialises it into a slave
//   frame (START, select bit, {cmd_type, cmd_data} body MSB first) and, for
//   read-data commands, captures MEMWIDTH bits of MISO after a turnaround and
//   returns them on a one-cycle response strobe.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command request
//   cmd_ready  high when a command can be accepted (IDLE only)
//   cmd_type   00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   cmd_data   address or write byte (ignored for type 11)
//   busy       inverse of cmd_ready
//   rsp_valid  one-cycle strobe carrying read data
//   rsp_data   received byte, held until the next strobe
//   SS_n       slave select, active low
//   MOSI       serial data to slave
//   MISO       serial data from slave (only sampled while receiving)
//
// MEMWIDTH must be at least 2.
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int MEMWIDTH    = 8,
    parameter int TURN_CYCLES = 1,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_type,
    input  logic [MEMWIDTH-1:0] cmd_data,
    output logic                busy,
    output logic                rsp_valid,
    output logic [MEMWIDTH-1:0] rsp_data,
    output logic                SS_n,
    output logic                MOSI,
    input  logic                MISO
);

    localparam int BODY_W  = MEMWIDTH + 2;
    localparam int CNT_MAX = (BODY_W > 16) ? BODY_W : 16;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(BODY_W - 1);
    localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(MEMWIDTH - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_SEL   = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_TURN  = 3'd4;
    localparam logic [2:0] ST_RECV  = 3'd5;
    localparam logic [2:0] ST_GAP   = 3'd6;

    logic [2:0]          state_r,     state_s;
    logic [CNT_W-1:0]    cnt_r,       cnt_s;
    logic [BODY_W-1:0]   shift_r,     shift_s;
    logic [MEMWIDTH-1:0] rx_r,        rx_s;
    logic                rd_r,        rd_s;
    logic                ss_n_r,      ss_n_s;
    logic                mosi_r,      mosi_s;
    logic                cmd_ready_r, cmd_ready_s;
    logic                busy_r;
    logic                rsp_valid_r, rsp_valid_s;
    logic [MEMWIDTH-1:0] rsp_data_r,  rsp_data_s;

    // Next-state, datapath and next-output computation
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        shift_s     = shift_r;
        rx_s        = rx_r;
        rd_s        = rd_r;
        rsp_valid_s = 1'b0;
        rsp_data_s  = rsp_data_r;

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = ST_START;
                    cnt_s   = CNT_ZERO;
                    shift_s = {cmd_type, cmd_data};
                    rd_s    = (cmd_type == 2'b11);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_s = ST_SEL;
            end
            ST_SEL: begin
                // Body starts unshifted so its first bit repeats the select bit.
                state_s = ST_SHIFT;
                cnt_s   = CNT_ZERO;
            end
            ST_SHIFT: begin
                if (cnt_r == SHIFT_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (rd_r) begin
                        if (TURN_CYCLES == 0) begin
                            state_s = ST_RECV;
                        end else begin
                            state_s = ST_TURN;
                        end
                    end else begin
                        state_s = ST_GAP;
                    end
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    shift_s = {shift_r[BODY_W-2:0], 1'b0};
                end
            end
            ST_TURN: begin
                if (cnt_r == TURN_LAST) begin
                    state_s = ST_RECV;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RECV: begin
                rx_s = {rx_r[MEMWIDTH-2:0], MISO};
                if (cnt_r == RECV_LAST) begin
                    state_s     = ST_GAP;
                    cnt_s       = CNT_ZERO;
                    rsp_valid_s = 1'b1;
                    rsp_data_s  = rx_s;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        ss_n_s      = (state_s == ST_IDLE) || (state_s == ST_GAP);
        cmd_ready_s = (state_s == ST_IDLE);
        if ((state_s == ST_SEL) || (state_s == ST_SHIFT)) begin
            mosi_s = shift_s[BODY_W-1];
        end else begin
            mosi_s = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            shift_r     <= {BODY_W{1'b0}};
            rx_r        <= {MEMWIDTH{1'b0}};
            rd_r        <= 1'b0;
            ss_n_r      <= 1'b1;
            mosi_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {MEMWIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            shift_r     <= shift_s;
            rx_r        <= rx_s;
            rd_r        <= rd_s;
            ss_n_r      <= ss_n_s;
            mosi_r      <= mosi_s;
            cmd_ready_r <= cmd_ready_s;
            busy_r      <= ~cmd_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_data_r  <= rsp_data_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign SS_n      = ss_n_r;
    assign MOSI      = mosi_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
//   Two DUT instances (default timing, and TURN_CYCLES=0 / GAP_CYCLES=1) are
//   exercised one after the other. A per-instance model tracks "cycles since
//   accept" and derives every expected output from the frame layout; a slave
//   model drives MISO inside the receive window and random noise elsewhere.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;
    localparam int MW = 8;

    logic clk = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int T  = (g == 0) ? 1 : 0;
        localparam int G  = (g == 0) ? 2 : 1;
        localparam int LW = MW + 4;           // SS_n-low cycles, types 00/01/10
        localparam int LR = MW + 4 + T + MW;  // SS_n-low cycles, type 11
        localparam int RS = MW + 5 + T;       // first receive cycle of a frame

        logic          rst       = 1'b1;
        logic          cmd_valid = 1'b0;
        logic [1:0]    cmd_type  = 2'b00;
        logic [MW-1:0] cmd_data  = '0;
        logic          miso      = 1'b0;
        logic          cmd_ready, busy, rsp_valid, ss_n, mosi;
        logic [MW-1:0] rsp_data;

        spi_master_ctrl #(.MEMWIDTH(MW), .TURN_CYCLES(T), .GAP_CYCLES(G)) dut (
            .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
            .cmd_type(cmd_type), .cmd_data(cmd_data), .busy(busy),
            .rsp_valid(rsp_valid), .rsp_data(rsp_data),
            .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
        );

        // Reference model state: active command and its cycle index k (1 = START)
        bit            act = 1'b0;
        int            k = 0;
        logic [1:0]    m_type = 2'b00;
        logic [MW-1:0] m_data = '0;
        logic [MW-1:0] m_byte = '0;
        logic [MW-1:0] m_rsp = '0;
        logic [MW-1:0] slave_byte = '0;
        int            accepts = 0, rsp_seen = 0, cyc = 0, prints = 0;
        int            low_len = 0, high_len = 0;
        logic [31:0]   bits = '0;
        int            flen_q[$];
        int            gap_q[$];
        logic [31:0]   fbits_q[$];

        function automatic int frame_len(input logic [1:0] t);
            return (t == 2'b11) ? LR : LW;
        endfunction

        // One clock: update model with the inputs seen at the edge, compare, log, drive MISO
        task automatic tick();
            int            len;
            logic [MW+1:0] body;
            logic          e_ss, e_mosi, e_rdy, e_rv;
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                act   = 1'b0;
                m_rsp = '0;
            end else if (!act) begin
                if (cmd_valid) begin
                    act = 1'b1; k = 1;
                    m_type = cmd_type; m_data = cmd_data; m_byte = slave_byte;
                    accepts++;
                end
            end else begin
                k++;
                if (k > frame_len(m_type) + G) act = 1'b0;
                else if (m_type == 2'b11 && k == frame_len(m_type) + 1) m_rsp = m_byte;
            end

            len    = frame_len(m_type);
            body   = {m_type, m_data};
            e_mosi = 1'b0;
            e_rv   = 1'b0;
            if (!act) begin
                e_ss = 1'b1; e_rdy = 1'b1;
            end else if (k <= len) begin
                e_ss = 1'b0; e_rdy = 1'b0;
                if (k == 2) e_mosi = m_type[1];
                else if (k >= 3 && k <= LW) e_mosi = body[LW-k];
            end else begin
                e_ss = 1'b1; e_rdy = 1'b0;
                e_rv = (m_type == 2'b11) && (k == len + 1);
            end

            vec_cnt++;
            if ({ss_n, mosi, cmd_ready, busy, rsp_valid, rsp_data} !==
                {e_ss, e_mosi, e_rdy, ~e_rdy, e_rv, m_rsp}) begin
                err_cnt++;
                if (prints < 20) begin
                    prints++;
                    $display("FAIL cycle inst%0d cyc%0d: got ss_n=%b mosi=%b rdy=%b busy=%b rv=%b rd=%h, expected %b %b %b %b %b %h",
                             g, cyc, ss_n, mosi, cmd_ready, busy, rsp_valid, rsp_data,
                             e_ss, e_mosi, e_rdy, ~e_rdy, e_rv, m_rsp);
                end
            end

            if (rsp_valid === 1'b1) rsp_seen++;
            if (ss_n === 1'b0) begin
                if (low_len == 0) gap_q.push_back(high_len);
                low_len++;
                bits = {bits[30:0], mosi};
            end else begin
                if (low_len > 0) begin
                    flen_q.push_back(low_len);
                    fbits_q.push_back(bits);
                    low_len = 0; bits = '0; high_len = 0;
                end
                high_len++;
            end

            if (act && m_type == 2'b11 && k >= RS && k < RS + MW) miso = m_byte[MW-1-(k-RS)];
            else miso = 1'($urandom());
        endtask

        task automatic issue(input logic [1:0] t, input logic [MW-1:0] d,
                             input logic [MW-1:0] sb, input bit drop);
            int a0, n;
            a0 = accepts; n = 0;
            cmd_valid = 1'b1; cmd_type = t; cmd_data = d; slave_byte = sb;
            while (accepts == a0 && n < 100) begin tick(); n++; end
            check("accept", 32'(accepts - a0), 32'd1);
            if (drop) cmd_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            while (act && n < 200) begin tick(); n++; end
            check("idle_timeout", {31'd0, act}, 32'd0);
            tick();
        endtask

        task automatic run();
            int          f0, r0, n;
            logic [7:0]  sweep [2];
            sweep = '{8'hFF, 8'h00};

            // reset held together with cmd_valid: nothing may be accepted
            rst = 1'b1; cmd_valid = 1'b1; cmd_type = 2'b11; cmd_data = 8'h81;
            repeat (3) tick();
            rst = 1'b0; cmd_valid = 1'b0;
            tick();
            check("reset_ss_n",  32'(ss_n),      32'd1);
            check("reset_mosi",  32'(mosi),      32'd0);
            check("reset_ready", 32'(cmd_ready), 32'd1);
            check("reset_busy",  32'(busy),      32'd0);
            check("reset_rv",    32'(rsp_valid), 32'd0);
            check("reset_rd",    32'(rsp_data),  32'd0);

            // write address then write data, valid held back-to-back
            f0 = flen_q.size();
            issue(2'b00, 8'hA5, 8'h00, 1'b0);
            issue(2'b01, 8'h3C, 8'h00, 1'b1);
            wait_idle();
            check("wa_len",  32'(flen_q[f0]),            32'd12);
            check("wa_bits", fbits_q[f0] & 32'hFFF,      32'h0A5);
            check("wd_len",  32'(flen_q[f0+1]),          32'd12);
            check("wd_bits", fbits_q[f0+1] & 32'hFFF,    32'h13C);
            check("wd_gap",  32'(gap_q[f0+1]),           32'(G + 1));

            // read address then read data
            f0 = flen_q.size(); r0 = rsp_seen;
            issue(2'b10, 8'h0F, 8'h00, 1'b1);
            issue(2'b11, 8'h00, 8'h5A, 1'b1);
            wait_idle();
            check("rd_byte",  32'(rsp_data),       32'h5A);
            check("rd_count", 32'(rsp_seen - r0),  32'd1);
            check("ra_len",   32'(flen_q[f0]),     32'd12);
            check("rdd_len",  32'(flen_q[f0+1]),   32'((g == 0) ? 21 : 20));

            // reset four cycles into the receive phase
            r0 = rsp_seen;
            issue(2'b11, 8'h00, 8'hC3, 1'b1);
            n = 0;
            while (!(act && k == RS + 4) && n < 100) begin tick(); n++; end
            check("reach_recv", 32'(k), 32'(RS + 4));
            rst = 1'b1; tick(); rst = 1'b0;
            check("rst_ss_n", 32'(ss_n),     32'd1);
            check("rst_mosi", 32'(mosi),     32'd0);
            check("rst_rd",   32'(rsp_data), 32'd0);
            repeat (30) tick();
            check("rst_no_rsp", 32'(rsp_seen - r0), 32'd0);
            issue(2'b11, 8'h00, 8'h96, 1'b1);
            wait_idle();
            check("post_rst_byte", 32'(rsp_data), 32'h96);

            // all-ones / all-zeros read data
            for (int i = 0; i < 2; i++) begin
                issue(2'b11, 8'($urandom()), sweep[i], 1'b1);
                wait_idle();
                check("sweep_byte", 32'(rsp_data), 32'(sweep[i]));
            end

            // four commands with cmd_valid never dropped
            f0 = flen_q.size();
            for (int i = 0; i < 4; i++) issue(2'(i), 8'($urandom()), 8'($urandom()), i == 3);
            wait_idle();
            repeat (10) tick();
            check("b2b_frames", 32'(flen_q.size() - f0), 32'd4);

            // random traffic with occasional resets
            for (int i = 0; i < 40; i++) begin
                issue(2'($urandom()), 8'($urandom()), 8'($urandom()), 1'($urandom()));
                if ($urandom_range(9) == 0) begin
                    repeat ($urandom_range(25)) tick();
                    rst = 1'b1; tick(); rst = 1'b0;
                end
                repeat ($urandom_range(3)) tick();
            end
            cmd_valid = 1'b0;
            wait_idle();
        endtask
    end

    initial begin
        g_inst[0].run();
        g_inst[1].run();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
